// File: rtl/ddr3_mem_pkg.sv
// ---------------------------------------------------------------------------
// ddr3_mem_pkg
// Shared types for the CPU-side DDR3 request scheduler: the queued request
// record, the scheduler state encoding and the default queue / burst sizes.
// ---------------------------------------------------------------------------
package ddr3_mem_pkg;

    localparam int DEPTH_DEF     = 4;   // request queue entries
    localparam int BURST_CYC_DEF = 4;   // controller data cycles per access

    typedef struct packed {
        logic        cmd;     // 1 = read, 0 = write
        logic [2:0]  ba;
        logic [14:0] row;
        logic [9:0]  col;
        logic [63:0] wdata;
    } ddr3_req_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_RD,
        S_WAIT_WR
    } sched_state_t;

endpackage

// File: rtl/ddr3_cpu_req_sched_if.sv
// ---------------------------------------------------------------------------
// ddr3_cpu_req_sched_if
// Bundles the CPU request port, the controller command/data port and the
// read-response port of the scheduler.
//   slave  : scheduler view (takes CPU requests, drives the controller)
//   master : environment view (CPU + controller model)
// ---------------------------------------------------------------------------
interface ddr3_cpu_req_sched_if;

    // CPU request side
    logic        req_valid;
    logic        req_ready;
    logic        req_cmd;
    logic [2:0]  req_ba;
    logic [14:0] req_row;
    logic [9:0]  req_col;
    logic [63:0] req_wdata;

    // controller side
    logic        cmd_rdy;
    logic        addr_valid;
    logic        cmd;
    logic [2:0]  ba;
    logic [14:0] addr;
    logic [9:0]  col;
    logic [63:0] wr_data;
    logic [63:0] rd_data_in;

    // read response
    logic        rsp_valid;
    logic [63:0] rsp_data;

    modport slave (
        input  req_valid, req_cmd, req_ba, req_row, req_col, req_wdata,
        input  cmd_rdy, rd_data_in,
        output req_ready, addr_valid, cmd, ba, addr, col, wr_data,
        output rsp_valid, rsp_data
    );

    modport master (
        output req_valid, req_cmd, req_ba, req_row, req_col, req_wdata,
        output cmd_rdy, rd_data_in,
        input  req_ready, addr_valid, cmd, ba, addr, col, wr_data,
        input  rsp_valid, rsp_data
    );

endinterface

// File: rtl/ddr3_req_fifo.sv
// ---------------------------------------------------------------------------
// ddr3_req_fifo
// DEPTH-entry FIFO of CPU requests. No bypass in either direction: a pushed
// entry reaches the head one cycle later, and a full queue refuses a push
// even when the head is popped in the same cycle.
//   clk_i, rst_i  : clock, synchronous active-high reset
//   push_i        : push request (accepted only while ready_o)
//   push_data_i   : request to store
//   pop_i         : remove head entry (ignored when empty)
//   head_o        : oldest entry
//   count_o       : number of stored entries
//   ready_o       : count_o < DEPTH
// ---------------------------------------------------------------------------
module ddr3_req_fifo
    import ddr3_mem_pkg::*;
#(
    parameter  int DEPTH = DEPTH_DEF,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  ddr3_req_t     push_data_i,
    input  logic          pop_i,
    output ddr3_req_t     head_o,
    output logic [CW-1:0] count_o,
    output logic          ready_o
);

    ddr3_req_t     mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok;
    logic          pop_ok;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign ready_o = (count_q < CW'(DEPTH));
    assign push_ok = push_i && ready_o;
    assign pop_ok  = pop_i && (count_q != '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (pop_ok)  rd_ptr_d = ptr_inc(rd_ptr_q);
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is only ever read at valid entries, so it carries no reset.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/ddr3_cpu_req_sched.sv
// ---------------------------------------------------------------------------
// ddr3_cpu_req_sched
// Queues CPU read/write requests and issues them one at a time to a DDR3
// controller, then waits out the BURST_CYC data cycles before the next issue.
// Reads return the controller data on a one-cycle rsp_valid strobe.
//   cpu_clk : sole clock
//   reset   : synchronous active-high reset, discards all queued/in-flight work
//   bus     : CPU request, controller command/data and response signals
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   S_IDLE    | queue empty, nothing in flight
//   S_ISSUE   | head entry presented with addr_valid, waiting for cmd_rdy
//   S_WAIT_RD | read burst in progress, response strobed in last cycle
//   S_WAIT_WR | write burst in progress, wr_data held stable
// ---------------------------------------------------------------------------
module ddr3_cpu_req_sched
    import ddr3_mem_pkg::*;
#(
    parameter int DEPTH     = DEPTH_DEF,
    parameter int BURST_CYC = BURST_CYC_DEF
) (
    input  logic                 cpu_clk,
    input  logic                 reset,
    ddr3_cpu_req_sched_if.slave  bus
);

    localparam int CW     = $clog2(DEPTH + 1);
    localparam int BW     = (BURST_CYC > 1) ? $clog2(BURST_CYC) : 1;
    localparam int RSP_AT = (BURST_CYC > 1) ? BURST_CYC - 2 : 0;

    ddr3_req_t     push_req;
    ddr3_req_t     head;
    logic [CW-1:0] count;
    logic          pop;

    sched_state_t  state_q;
    logic [BW-1:0] burst_q;
    ddr3_req_t     issue_q;
    logic          addr_valid_q;
    logic          rsp_valid_q;
    logic [63:0]   rsp_data_q;

    logic          burst_last;
    logic          rsp_due;

    assign push_req = {bus.req_cmd, bus.req_ba, bus.req_row, bus.req_col, bus.req_wdata};

    // addr_valid is only high in S_ISSUE, so the handshake pops the head.
    assign pop = (state_q == S_ISSUE) && bus.cmd_rdy;

    ddr3_req_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i       (cpu_clk),
        .rst_i       (reset),
        .push_i      (bus.req_valid),
        .push_data_i (push_req),
        .pop_i       (pop),
        .head_o      (head),
        .count_o     (count),
        .ready_o     (bus.req_ready)
    );

    assign burst_last = (burst_q == BW'(BURST_CYC - 1));
    // The response register loads one edge early so that rsp_valid is
    // visible during the final burst cycle rather than after it.
    assign rsp_due    = (BURST_CYC > 1) && (burst_q == BW'(RSP_AT));

    always_ff @(posedge cpu_clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            burst_q      <= '0;
            issue_q      <= '0;
            addr_valid_q <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (count != '0) begin
                        state_q      <= S_ISSUE;
                        addr_valid_q <= 1'b1;
                        issue_q      <= head;
                    end
                end
                S_ISSUE: begin
                    if (bus.cmd_rdy) begin
                        addr_valid_q <= 1'b0;
                        burst_q      <= '0;
                        state_q      <= issue_q.cmd ? S_WAIT_RD : S_WAIT_WR;
                        if (issue_q.cmd && (BURST_CYC == 1)) begin
                            rsp_valid_q <= 1'b1;
                            rsp_data_q  <= bus.rd_data_in;
                        end
                    end
                end
                S_WAIT_RD, S_WAIT_WR: begin
                    burst_q <= burst_q + 1'b1;
                    if ((state_q == S_WAIT_RD) && rsp_due) begin
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= bus.rd_data_in;
                    end
                    if (burst_last) begin
                        if (count != '0) begin
                            state_q      <= S_ISSUE;
                            addr_valid_q <= 1'b1;
                            issue_q      <= head;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.addr_valid = addr_valid_q;
    assign bus.cmd        = issue_q.cmd;
    assign bus.ba         = issue_q.ba;
    assign bus.addr       = issue_q.row;
    assign bus.col        = issue_q.col;
    assign bus.wr_data    = issue_q.wdata;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_data   = rsp_data_q;

endmodule

// File: doc/ddr3_cpu_req_sched.md
DDR3_CPU_REQ_SCHED -- requirements
Module: ddr3_cpu_req_sched

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- DEPTH, 4, request queue entries
- BURST_CYC, 4, controller data cycles per access (READ0..READ3 / WRITE0..WRITE3)

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- cpu_clk, in, 1, sole clock; all logic on its rising edge
- reset, in, 1, synchronous, active-high
- req_valid, in, 1, CPU request present
- req_ready, out, 1, queue can accept a request
- req_cmd, in, 1, 1 = read, 0 = write
- req_ba, in, 3, bank address
- req_row, in, 15, row address
- req_col, in, 10, column address
- req_wdata, in, 64, write data (one 8-beat burst)
- cmd_rdy, in, 1, controller CMD_RDY
- addr_valid, out, 1, controller ADDR_VALID
- cmd, out, 1, controller CMD
- ba, out, 3, controller BA
- addr, out, 15, controller ADDR (row)
- col, out, 10, controller COL
- wr_data, out, 64, controller WR_DATA
- rd_data_in, in, 64, controller RD_DATA
- rsp_valid, out, 1, one-cycle read-response strobe
- rsp_data, out, 64, read response data

Function
REQ-003 Push SHALL occur when req_valid && req_ready; req_ready = (count < DEPTH).
REQ-004 When count == DEPTH, req_ready SHALL be 0 even if a pop occurs in the same cycle (no full-bypass).
REQ-005 The queue SHALL be FIFO ordered; a pushed entry SHALL first be visible at the head on the next cycle (no empty-bypass).
REQ-006 Simultaneous push and pop with 0 < count < DEPTH SHALL leave count unchanged.
REQ-007 Read and write pointers SHALL wrap modulo DEPTH; count SHALL be ceil(log2(DEPTH+1)) bits wide.
REQ-008 The FSM SHALL have states S_IDLE, S_ISSUE, S_WAIT_RD and S_WAIT_WR.
REQ-009 S_IDLE SHALL go to S_ISSUE when count != 0.
REQ-010 In S_ISSUE, addr_valid SHALL be 1 and cmd/ba/addr/col/wr_data SHALL present the head entry.
REQ-011 Issue handshake SHALL complete when addr_valid && cmd_rdy; on completion the head SHALL pop and the FSM SHALL go to S_WAIT_RD (cmd = 1) or S_WAIT_WR (cmd = 0).
REQ-012 Outside S_ISSUE, addr_valid SHALL be 0.
REQ-013 Issued fields SHALL be held in a register and wr_data SHALL remain stable through the whole S_WAIT_WR period.
REQ-014 The burst counter SHALL clear on entry to a wait state and SHALL increment each cycle; the wait SHALL end when the counter reaches BURST_CYC-1.
REQ-015 At the end of S_WAIT_RD, rsp_data SHALL latch rd_data_in and rsp_valid SHALL pulse for exactly one cycle.
REQ-016 rsp_data SHALL hold its value until the next read completes.
REQ-017 At the end of a wait, the FSM SHALL go to S_ISSUE if count != 0, else to S_IDLE.
REQ-018 Write completions SHALL produce no response.
REQ-019 Minimum issue-to-issue spacing SHALL be BURST_CYC+1 cycles.

Reset
REQ-020 While reset = 1 at a clock edge, the block SHALL set: FSM = S_IDLE; pointers, count and burst counter = 0; addr_valid = 0, rsp_valid = 0, req_ready = 1; cmd/ba/addr/col = 0; wr_data and rsp_data = 0.
REQ-021 Reset mid-operation SHALL discard all queued and in-flight requests, with no rsp_valid afterwards for them.

Structure
REQ-022 ddr3_mem_pkg SHALL hold the request struct typedef (cmd, ba, row, col, wdata), the sched state enum, and the DEPTH and BURST_CYC defaults.
REQ-023 Queue storage and pointers SHALL be a sub-module, ddr3_req_fifo; the FSM, burst counter and response register SHALL be in ddr3_cpu_req_sched.

Verification
REQ-024 After reset, push read (ba = 3, row = 0x1A2B, col = 0x040) with cmd_rdy = 1 -> addr_valid seen 2 cycles after push with matching fields; rsp_valid seen 4 cycles after the handshake with rsp_data = rd_data_in (0xDEADBEEF_01234567).
REQ-025 Push 4 writes with cmd_rdy = 0 -> req_ready = 0 after the 4th push; a 5th req_valid is not accepted; raise cmd_rdy -> 4 issues in order, spaced 5 cycles apart.
REQ-026 Full queue plus push and pop in the same cycle -> push refused; count = 3 next cycle.
REQ-027 Alternate write/read to the same row for 6 requests -> pointers wrap; order preserved; exactly 3 rsp_valid pulses.
REQ-028 Assert reset during S_WAIT_RD with 2 entries queued -> next cycle: addr_valid = 0, req_ready = 1, and no rsp_valid thereafter.
